// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel stage: two line buffers, a 3x3 window and a two-stage gx/gy pipeline.
// Define SOBEL_MAG_EN to build the |gx|+|gy| magnitude output; otherwise mag is tied to zero.
//
// state | meaning
// IDLE  | waiting for pix_sof; other pixels are accepted and dropped
// RUN   | frame in progress; col/row track the next pixel to arrive
module sobel_gradient #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pix_in,
    input  logic               pix_sof,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic signed [10:0] gx,
    output logic signed [10:0] gy,
    output logic [10:0]        mag,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_e;
    logic [RW-1:0] row_q, row_d, row_e;
    logic          stall, adv, accept, take, emit;

    assign stall     = out_valid && !out_ready;
    assign adv       = !stall;
    assign pix_ready = adv;
    assign accept    = pix_valid && adv;

    // col_e/row_e: coordinates of the pixel being accepted this cycle
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        col_e   = col_q;
        row_e   = row_q;
        take    = 1'b0;
        if (accept) begin
            if (pix_sof) begin
                take    = 1'b1;
                col_e   = '0;
                row_e   = '0;
                col_d   = CW'(1);
                row_d   = '0;
                state_d = S_RUN;
            end else if (state_q == S_RUN) begin
                take = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    assign emit = take && (row_e >= ROW_TWO) && (col_e >= COL_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // line buffers hold lines r-1 (lb1) and r-2 (lb2); no reset needed
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];
    logic [7:0] col_top, col_mid;

    assign col_top = lb2[col_e];
    assign col_mid = lb1[col_e];

    always_ff @(posedge clk) begin
        if (take) begin
            lb1[col_e] <= pix_in;
            lb2[col_e] <= lb1[col_e];
        end
    end

    logic [7:0] win [3][3];
    logic       wv, wsof, weol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            wv   <= 1'b0;
            wsof <= 1'b0;
            weol <= 1'b0;
        end else if (adv) begin
            wv   <= emit;
            wsof <= emit && (row_e == ROW_TWO) && (col_e == COL_TWO);
            weol <= emit && (col_e == COL_LAST);
            if (take) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= col_top;
                win[1][2] <= col_mid;
                win[2][2] <= pix_in;
            end
        end
    end

    // S1: weighted column sums (for gx) and bottom-minus-top differences (for gy)
    logic [9:0]        sum_l, sum_r;
    logic signed [8:0] d0, d1, d2;
    logic signed [9:0] dsum;

    always_comb begin
        sum_l = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
        sum_r = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
        d0    = $signed({1'b0, win[2][0]}) - $signed({1'b0, win[0][0]});
        d1    = $signed({1'b0, win[2][1]}) - $signed({1'b0, win[0][1]});
        d2    = $signed({1'b0, win[2][2]}) - $signed({1'b0, win[0][2]});
        dsum  = $signed({d0[8], d0}) + $signed({d2[8], d2});
    end

    logic [9:0]        s1_suml, s1_sumr;
    logic signed [9:0] s1_dsum;
    logic signed [8:0] s1_d1;
    logic              s1v, s1sof, s1eol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_suml <= '0;
            s1_sumr <= '0;
            s1_dsum <= '0;
            s1_d1   <= '0;
            s1v     <= 1'b0;
            s1sof   <= 1'b0;
            s1eol   <= 1'b0;
        end else if (adv) begin
            s1_suml <= sum_l;
            s1_sumr <= sum_r;
            s1_dsum <= dsum;
            s1_d1   <= d1;
            s1v     <= wv;
            s1sof   <= wsof;
            s1eol   <= weol;
        end
    end

    // S2: final gradients; range is +/-1020 so 11 signed bits never overflow
    logic signed [10:0] gx_c, gy_c;

    always_comb begin
        gx_c = $signed({1'b0, s1_sumr}) - $signed({1'b0, s1_suml});
        gy_c = $signed({s1_dsum[9], s1_dsum}) + $signed({s1_d1[8], s1_d1, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx        <= '0;
            gy        <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (adv) begin
            gx        <= gx_c;
            gy        <= gy_c;
            out_valid <= s1v;
            out_sof   <= s1sof;
            out_eol   <= s1eol;
        end
    end

`ifdef SOBEL_MAG_EN
    logic [10:0] abs_gx, abs_gy, mag_c;

    always_comb begin
        abs_gx = gx_c[10] ? 11'(-gx_c) : 11'(gx_c);
        abs_gy = gy_c[10] ? 11'(-gy_c) : 11'(gy_c);
        mag_c  = abs_gx + abs_gy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mag <= '0;
        else if (adv)
            mag <= mag_c;
    end
`else
    assign mag = '0;
`endif

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient on an 8x6 image: frame-level model plus literal pins.
module tb_sobel_gradient;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [10:0] gx, gy, mag;
    logic        out_sof, out_eol, out_valid;
    logic        out_ready = 1'b1;

    sobel_gradient #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_sof(pix_sof),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .gx(gx), .gy(gy), .mag(mag),
        .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {int gx; int gy; bit sof; bit eol;} res_t;
    res_t expq[$];
    int   img [H][W];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   bp_mode = 1'b0;
    int   obs_gx [64];
    int   obs_gy [64];
    bit   obs_sof [64];
    bit   obs_eol [64];
    int   obs_n = 0;
    bit   pstall = 1'b0;
    int   pgx, pgy, pmag;
    bit   psof, peol;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sobel straight from the window definition, p[i][j] = img[r-1+i][c-1+j]
    function automatic void calc(input int r, input int c, output int ogx, output int ogy);
        ogx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
            - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        ogy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
            - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    endfunction

    function automatic int exp_mag(input int a, input int b);
`ifdef SOBEL_MAG_EN
        return (a < 0 ? -a : a) + (b < 0 ? -b : b);
`else
        return 0;
`endif
    endfunction

    // expected results when the first npix raster pixels of img are delivered
    function automatic void push_frame(input int npix);
        res_t e;
        for (int r = 1; r < H-1; r++)
            for (int c = 1; c < W-1; c++)
                if ((r+1)*W + (c+1) < npix) begin
                    calc(r, c, e.gx, e.gy);
                    e.sof = (r == 1 && c == 1);
                    e.eol = (c == W-2);
                    expq.push_back(e);
                end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bp_mode) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else         out_ready = 1'b1;
    end

    // compare process: transfers and stall stability, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pstall = 1'b0;
        end else begin
            check("pix_ready", int'(pix_ready), int'(!(out_valid && !out_ready)));
            if (pstall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_gx", int'($signed(gx)), pgx);
                check("stall_gy", int'($signed(gy)), pgy);
                check("stall_mag", int'(mag), pmag);
                check("stall_sof", int'(out_sof), int'(psof));
                check("stall_eol", int'(out_eol), int'(peol));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got gx=%0d gy=%0d expected none (t=%0t)",
                             $signed(gx), $signed(gy), $time);
                end else begin
                    res_t e;
                    e = expq.pop_front();
                    check("gx", int'($signed(gx)), e.gx);
                    check("gy", int'($signed(gy)), e.gy);
                    check("mag", int'(mag), exp_mag(e.gx, e.gy));
                    check("out_sof", int'(out_sof), int'(e.sof));
                    check("out_eol", int'(out_eol), int'(e.eol));
                end
                if (obs_n < 64) begin
                    obs_gx[obs_n]  = int'($signed(gx));
                    obs_gy[obs_n]  = int'($signed(gy));
                    obs_sof[obs_n] = out_sof;
                    obs_eol[obs_n] = out_eol;
                end
                obs_n++;
            end
            pstall = out_valid && !out_ready;
            pgx  = int'($signed(gx));
            pgy  = int'($signed(gy));
            pmag = int'(mag);
            psof = out_sof;
            peol = out_eol;
        end
    end

    task automatic idle(input int n);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [7:0] p, input logic sof);
        bit acc;
        int guard;
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        guard     = 0;
        forever begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", guard, 0);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_range(input int a, input int b, input bit gaps);
        for (int i = a; i < b; i++) begin
            send_pix(8'(img[i / W][i % W]), i == 0);
            if (gaps && (i % 5 == 4)) idle(1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", expq.size(), 0);
    endtask

    initial begin
        int mgx, mgy, base;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_pix_ready", int'(pix_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_gx", int'(gx), 0);
        check("rst_gy", int'(gy), 0);
        check("rst_mag", int'(mag), 0);
        check("rst_sof_eol", int'({out_sof, out_eol}), 0);

        // constant image, with a latency probe on the first result
        foreach (img[r, c]) img[r][c] = 77;
        obs_n = 0;
        push_frame(W*H);
        send_range(0, 19, 1'b0);
        check("lat_edge0", int'(out_valid), 0);
        idle(1);
        check("lat_edge1", int'(out_valid), 0);
        idle(1);
        check("lat_edge2", int'(out_valid), 1);
        check("lat_sof", int'(out_sof), 1);
        send_range(19, W*H, 1'b0);
        drain();
        check("const_count", obs_n, 24);
        check("const_sof0", int'(obs_sof[0]), 1);
        check("const_eol5", int'(obs_eol[5]), 1);
        check("const_eol4", int'(obs_eol[4]), 0);
        check("const_eol23", int'(obs_eol[23]), 1);

        // vertical step 0 | 100
        foreach (img[r, c]) img[r][c] = (c < 4) ? 0 : 100;
        calc(2, 3, mgx, mgy);
        check("model_step_gx", mgx, 400);
        calc(2, 2, mgx, mgy);
        check("model_step_gx_flat", mgx, 0);
        obs_n = 0;
        push_frame(W*H);
        send_range(0, W*H, 1'b0);
        drain();
        check("step_count", obs_n, 24);
        check("step_gx_c3", obs_gx[2], 400);
        check("step_gx_c4", obs_gx[3], 400);
        check("step_gy_c3", obs_gy[2], 0);
        check("step_gx_c1", obs_gx[0], 0);

        // vertical ramp, with input bubbles
        foreach (img[r, c]) img[r][c] = 10 * r;
        calc(2, 2, mgx, mgy);
        check("model_ramp_gy", mgy, 80);
        obs_n = 0;
        push_frame(W*H);
        send_range(0, W*H, 1'b1);
        drain();
        check("ramp_count", obs_n, 24);
        check("ramp_gy0", obs_gy[0], 80);
        check("ramp_gx0", obs_gx[0], 0);

        // full-range step 0 | 255
        foreach (img[r, c]) img[r][c] = (c < 4) ? 0 : 255;
        calc(1, 3, mgx, mgy);
        check("model_full_gx", mgx, 1020);
        obs_n = 0;
        push_frame(W*H);
        send_range(0, W*H, 1'b0);
        drain();
        check("full_gx_c3", obs_gx[8], 1020);
        check("full_gx_c4", obs_gx[9], 1020);

        // backpressure 1,0,0,1
        foreach (img[r, c]) img[r][c] = 77;
        bp_mode = 1'b1;
        obs_n = 0;
        push_frame(W*H);
        send_range(0, W*H, 1'b0);
        drain();
        bp_mode = 1'b0;
        check("bp_count", obs_n, 24);
        check("bp_sof0", int'(obs_sof[0]), 1);
        check("bp_eol23", int'(obs_eol[23]), 1);

        // junk then restart at pixel (3,4)
        obs_n = 0;
        for (int i = 0; i < 5; i++) send_pix(8'(8'hA5 + i), 1'b0);
        idle(4);
        check("junk_no_output", obs_n, 0);
        foreach (img[r, c]) img[r][c] = (r*37 + c*11) % 256;
        push_frame(3*W + 4);
        send_range(0, 3*W + 4, 1'b0);
        foreach (img[r, c]) img[r][c] = (r*13 + c*c*7) % 256;
        push_frame(W*H);
        send_range(0, W*H, 1'b0);
        drain();
        check("restart_count", obs_n, 8 + 24);
        check("restart_sof_old", int'(obs_sof[0]), 1);
        check("restart_sof_new", int'(obs_sof[8]), 1);

        // reset mid-frame
        foreach (img[r, c]) img[r][c] = (r*50 + c*3) % 256;
        push_frame(30);
        send_range(0, 30, 1'b0);
        rst_n = 1'b0;
        expq.delete();
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_gx", int'(gx), 0);
        check("mid_rst_gy", int'(gy), 0);
        check("mid_rst_mag", int'(mag), 0);
        check("mid_rst_flags", int'({out_sof, out_eol}), 0);
        idle(2);
        rst_n = 1'b1;
        base = obs_n;
        for (int i = 0; i < 10; i++) send_pix(8'(i * 20), 1'b0);
        idle(5);
        check("post_rst_no_output", obs_n, base);
        foreach (img[r, c]) img[r][c] = (r*29 + c*43) % 256;
        push_frame(W*H);
        send_range(0, W*H, 1'b0);
        drain();
        check("post_rst_count", obs_n - base, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
